exe_up_gen: RTL and testbench

//  Parametrised EXE-upper stage: latches one issued instruction from ID and resolves operands from regfile, immediate or one of NUM_FWD forward sources.

---
 rtl/exe_up_gen.sv | 172 +++++++++++++++++
 tb/tb_exe_up_gen.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_up_gen.sv
// exe_up_gen: EXE-upper stage; latches one instruction, resolves operands (waiting on forwards), computes ALU/exception/branch repair.
module exe_up_gen #(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 6,
  parameter int REG_W   = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_allowin,
  input  logic [REG_W-1:0]            in_wnum,
  input  logic [2*DATA_W-1:0]         in_rs_data,
  input  logic [2*DATA_W-1:0]         in_imm,
  input  logic [1:0]                  in_is_reg,
  input  logic [2*(NUM_FWD+1)-1:0]    in_fwd_sel,
  input  logic [3:0]                  in_aluop,
  input  logic [DATA_W-1:0]           in_pc,
  input  logic                        in_exc,
  input  logic                        in_ov_en,
  input  logic                        in_trap_en,
  input  logic [1:0]                  in_trap_kind,
  input  logic [2:0]                  in_br_kind,
  input  logic [DATA_W-1:0]           in_br_target,
  input  logic                        in_pred_take,
  input  logic [DATA_W-1:0]           in_pred_dest,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_data,
  input  logic [NUM_FWD-1:0]          fwd_valid,
  output logic                        out_valid,
  input  logic                        out_allowin,
  output logic [REG_W-1:0]            out_wnum,
  output logic [DATA_W-1:0]           out_pc,
  output logic [DATA_W-1:0]           out_alu_res,
  output logic                        out_exc,
  output logic                        out_corr_take,
  output logic [DATA_W-1:0]           out_corr_dest,
  output logic                        out_mispred
);
  localparam int FS = NUM_FWD + 1;
  localparam int SW = $clog2(DATA_W);
  localparam int M  = DATA_W - 1;
  typedef enum logic [1:0] {EMPTY, WAIT, READY} state_t;
  typedef struct packed {
    logic [REG_W-1:0]  wnum;
    logic [DATA_W-1:0] pc;
    logic [3:0]        aluop;
    logic              exc;
    logic              ov_en;
    logic              trap_en;
    logic [1:0]        trap_kind;
    logic [2:0]        br_kind;
    logic [DATA_W-1:0] br_target;
    logic              pred_take;
    logic [DATA_W-1:0] pred_dest;
  } pl_t;
  state_t state_q, state_d;
  pl_t pl_q, pl_d;
  logic [1:0][DATA_W-1:0] opnd_q, opnd_d, pick_d;
  logic [1:0][FS-1:0] sel_q, sel_d, cur_sel;
  logic [1:0] rdy_q, rdy_d, pick_v;
  logic accept, ovf, trap, take;
  logic [DATA_W-1:0] a, b, sum, diff, res;
  assign in_allowin = state_q == EMPTY || (state_q == READY && out_allowin && !flush);
  assign accept = in_valid && in_allowin && !flush;
  // forward select comes from the incoming instruction at accept, else from the parked selection
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cur_sel[i] = accept ? in_fwd_sel[i*FS +: FS] : sel_q[i];
      pick_v[i] = 1'b0;
      pick_d[i] = '0;
      for (int k = 0; k < NUM_FWD; k++) begin
        pick_v[i] = pick_v[i] | (cur_sel[i][k+1] & fwd_valid[k]);
        pick_d[i] = pick_d[i] | (cur_sel[i][k+1] ? fwd_data[k*DATA_W +: DATA_W] : '0);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    pl_d = pl_q;
    opnd_d = opnd_q;
    sel_d = sel_q;
    rdy_d = rdy_q;
    if (accept) begin
      pl_d = '{wnum: in_wnum, pc: in_pc, aluop: in_aluop, exc: in_exc, ov_en: in_ov_en,
               trap_en: in_trap_en, trap_kind: in_trap_kind, br_kind: in_br_kind,
               br_target: in_br_target, pred_take: in_pred_take, pred_dest: in_pred_dest};
      sel_d = cur_sel;
      for (int i = 0; i < 2; i++) begin
        rdy_d[i] = !in_is_reg[i] || cur_sel[i][0] || pick_v[i];
        opnd_d[i] = !in_is_reg[i] ? in_imm[i*DATA_W +: DATA_W] :
                    cur_sel[i][0] ? in_rs_data[i*DATA_W +: DATA_W] :
                    pick_v[i] ? pick_d[i] : '0;
      end
      state_d = &rdy_d ? READY : WAIT;
    end else if (flush || (state_q == READY && out_allowin)) begin
      state_d = EMPTY;
      pl_d = '0;
      opnd_d = '0;
      sel_d = '0;
      rdy_d = '0;
    end else if (state_q == WAIT) begin
      for (int i = 0; i < 2; i++) begin
        if (!rdy_q[i] && pick_v[i]) begin
          opnd_d[i] = pick_d[i];
          rdy_d[i] = 1'b1;
        end
      end
      state_d = &rdy_d ? READY : WAIT;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      pl_q <= '0;
      opnd_q <= '0;
      sel_q <= '0;
      rdy_q <= '0;
    end else begin
      state_q <= state_d;
      pl_q <= pl_d;
      opnd_q <= opnd_d;
      sel_q <= sel_d;
      rdy_q <= rdy_d;
    end
  end
  assign a = opnd_q[0];
  assign b = opnd_q[1];
  assign sum = a + b;
  assign diff = a - b;
  always_comb begin
    res = '0;
    case (pl_q.aluop)
      4'd0:    res = sum;
      4'd1:    res = diff;
      4'd2:    res = a & b;
      4'd3:    res = a | b;
      4'd4:    res = a ^ b;
      4'd5:    res = ~(a | b);
      4'd6:    res = {{M{1'b0}}, $signed(a) < $signed(b)};
      4'd7:    res = {{M{1'b0}}, a < b};
      4'd8:    res = b << a[SW-1:0];
      4'd9:    res = b >> a[SW-1:0];
      4'd10:   res = $signed(b) >>> a[SW-1:0];
      4'd11:   res = b;
      default: res = '0;
    endcase
    ovf = (pl_q.aluop == 4'd0 && a[M] == b[M] && sum[M] != a[M]) ||
          (pl_q.aluop == 4'd1 && a[M] != b[M] && diff[M] != a[M]);
    trap = pl_q.trap_kind == 2'd0 ? res == '0 :
           pl_q.trap_kind == 2'd1 ? res != '0 :
           pl_q.trap_kind == 2'd2 ? res[0] : !res[0];
    case (pl_q.br_kind)
      3'd1:    take = a == b;
      3'd2:    take = a != b;
      3'd3:    take = a[M];
      3'd4:    take = a[M] || a == '0;
      3'd5:    take = !a[M] && a != '0;
      3'd6:    take = !a[M];
      3'd7:    take = 1'b1;
      default: take = 1'b0;
    endcase
  end
  assign out_valid = state_q == READY && !flush;
  assign out_wnum = pl_q.wnum;
  assign out_pc = pl_q.pc;
  assign out_alu_res = res;
  assign out_exc = pl_q.exc || (pl_q.ov_en && ovf) || (pl_q.trap_en && trap);
  assign out_corr_take = take;
  assign out_corr_dest = pl_q.br_kind == 3'd7 ? a : pl_q.br_target;
  assign out_mispred = pl_q.br_kind != 3'd0 &&
                       (take != pl_q.pred_take || (take && out_corr_dest != pl_q.pred_dest));
endmodule

// File: tb/tb_exe_up_gen.sv
// tb_exe_up_gen: directed and randomized checks of exe_up_gen against an arithmetic reference model.
module tb_exe_up_gen;
  logic clk, rst, flush, in_valid, in_allowin, in_exc, in_ov_en, in_trap_en, in_pred_take;
  logic [4:0] in_wnum, out_wnum;
  logic [63:0] in_rs_data, in_imm;
  logic [1:0] in_is_reg, in_trap_kind;
  logic [13:0] in_fwd_sel;
  logic [3:0] in_aluop;
  logic [2:0] in_br_kind;
  logic [31:0] in_pc, in_br_target, in_pred_dest, out_pc, out_alu_res, out_corr_dest;
  logic [191:0] fwd_data;
  logic [5:0] fwd_valid;
  logic out_valid, out_allowin, out_exc, out_corr_take, out_mispred;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [4:0] wnum;
    logic [31:0] pc, a, b, tgt, pd;
    logic [3:0] op;
    int s0, s1, f0, f1, d0, d1;
    logic exc, ov_en, trap_en, pt;
    logic [1:0] tk;
    logic [2:0] br;
  } ins_t;
  exe_up_gen dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_allowin(in_allowin),
    .in_wnum(in_wnum), .in_rs_data(in_rs_data), .in_imm(in_imm), .in_is_reg(in_is_reg),
    .in_fwd_sel(in_fwd_sel), .in_aluop(in_aluop), .in_pc(in_pc), .in_exc(in_exc),
    .in_ov_en(in_ov_en), .in_trap_en(in_trap_en), .in_trap_kind(in_trap_kind),
    .in_br_kind(in_br_kind), .in_br_target(in_br_target), .in_pred_take(in_pred_take),
    .in_pred_dest(in_pred_dest), .fwd_data(fwd_data), .fwd_valid(fwd_valid),
    .out_valid(out_valid), .out_allowin(out_allowin), .out_wnum(out_wnum), .out_pc(out_pc),
    .out_alu_res(out_alu_res), .out_exc(out_exc), .out_corr_take(out_corr_take),
    .out_corr_dest(out_corr_dest), .out_mispred(out_mispred)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic void model(input ins_t t, output logic [31:0] r, output logic e,
                                output logic tk, output logic [31:0] d, output logic m);
    longint sa = longint'($signed(t.a));
    longint sb = longint'($signed(t.b));
    longint s = 0;
    int sh = int'(t.a & 32'd31);
    logic ovf = 0;
    logic tr;
    case (t.op)
      0: begin s = sa + sb; r = s[31:0]; ovf = s > 64'sd2147483647 || s < -64'sd2147483648; end
      1: begin s = sa - sb; r = s[31:0]; ovf = s > 64'sd2147483647 || s < -64'sd2147483648; end
      2: r = t.a & t.b;
      3: r = t.a | t.b;
      4: r = t.a ^ t.b;
      5: r = ~(t.a | t.b);
      6: r = (sa < sb) ? 32'd1 : 32'd0;
      7: r = (t.a < t.b) ? 32'd1 : 32'd0;
      8: r = t.b << sh;
      9: r = t.b >> sh;
      10: begin s = sb >>> sh; r = s[31:0]; end
      11: r = t.b;
      default: r = 0;
    endcase
    case (t.tk)
      0: tr = r == 0;
      1: tr = r != 0;
      2: tr = r[0];
      default: tr = !r[0];
    endcase
    e = t.exc | (t.ov_en & ovf) | (t.trap_en & tr);
    case (t.br)
      1: tk = t.a == t.b;
      2: tk = t.a != t.b;
      3: tk = sa < 0;
      4: tk = sa <= 0;
      5: tk = sa > 0;
      6: tk = sa >= 0;
      7: tk = 1;
      default: tk = 0;
    endcase
    d = (t.br == 7) ? t.a : t.tgt;
    m = (t.br != 0) && (tk != t.pt || (tk && d != t.pd));
  endfunction
  function automatic ins_t rand_ins();
    ins_t t;
    logic [31:0] edges [4] = '{32'h0, 32'h7fffffff, 32'h80000000, 32'hffffffff};
    t.wnum = 5'($urandom);
    t.pc = $urandom;
    t.op = 4'($urandom);
    t.a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
    t.b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
    if ($urandom_range(0, 5) == 0) t.b = t.a;
    t.s0 = $urandom_range(0, 2);
    t.s1 = $urandom_range(0, 2);
    t.f0 = $urandom_range(0, 5);
    t.f1 = $urandom_range(0, 5);
    t.d0 = $urandom_range(0, 3);
    t.d1 = $urandom_range(0, 3);
    if (t.s0 == 2 && t.s1 == 2 && t.f0 == t.f1) begin
      t.b = t.a;
      t.d1 = t.d0;
    end
    t.exc = ($urandom_range(0, 7) == 0);
    t.ov_en = 1'($urandom);
    t.trap_en = 1'($urandom);
    t.tk = 2'($urandom);
    t.br = 3'($urandom);
    t.tgt = $urandom;
    t.pt = 1'($urandom);
    t.pd = $urandom_range(0, 1) ? ((t.br == 7) ? t.a : t.tgt) : $urandom;
    return t;
  endfunction
  task automatic set_src(input int i, input int s, input int f, input logic [31:0] v);
    in_is_reg[i] = (s != 0);
    in_fwd_sel[i*7 +: 7] = (s == 2) ? 7'(1 << (f + 1)) : (s == 1) ? 7'd1 : 7'(1 << $urandom_range(0, 6));
    if (s == 0) in_imm[i*32 +: 32] = v;
    if (s == 1) in_rs_data[i*32 +: 32] = v;
  endtask
  task automatic set_fwd(input ins_t t, input int c);
    for (int k = 0; k < 6; k++) fwd_data[k*32 +: 32] = $urandom;
    fwd_valid = 6'($urandom);
    if (t.s0 == 2) begin
      fwd_valid[t.f0] = (c == t.d0) ? 1'b1 : (c < t.d0) ? 1'b0 : 1'($urandom);
      if (c == t.d0) fwd_data[t.f0*32 +: 32] = t.a;
    end
    if (t.s1 == 2) begin
      fwd_valid[t.f1] = (c == t.d1) ? 1'b1 : (c < t.d1) ? 1'b0 : 1'($urandom);
      if (c == t.d1) fwd_data[t.f1*32 +: 32] = t.b;
    end
  endtask
  task automatic drive_accept(input ins_t t);
    in_valid = 1;
    in_wnum = t.wnum;
    in_pc = t.pc;
    in_aluop = t.op;
    in_exc = t.exc;
    in_ov_en = t.ov_en;
    in_trap_en = t.trap_en;
    in_trap_kind = t.tk;
    in_br_kind = t.br;
    in_br_target = t.tgt;
    in_pred_take = t.pt;
    in_pred_dest = t.pd;
    in_rs_data = {$urandom, $urandom};
    in_imm = {$urandom, $urandom};
    set_src(0, t.s0, t.f0, t.a);
    set_src(1, t.s1, t.f1, t.b);
    set_fwd(t, 0);
  endtask
  task automatic scramble();
    in_rs_data = {$urandom, $urandom};
    in_imm = {$urandom, $urandom};
    in_pc = $urandom;
    in_aluop = 4'($urandom);
    in_br_target = $urandom;
  endtask
  task automatic check_out(input string tag, input ins_t t);
    logic [31:0] r, d;
    logic e, tk, m;
    model(t, r, e, tk, d, m);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".wnum"}, out_wnum, t.wnum);
    chk({tag, ".pc"}, out_pc, t.pc);
    chk({tag, ".res"}, out_alu_res, r);
    chk({tag, ".exc"}, out_exc, e);
    chk({tag, ".take"}, out_corr_take, tk);
    chk({tag, ".dest"}, out_corr_dest, d);
    chk({tag, ".mispred"}, out_mispred, m);
  endtask
  task automatic run_instr(input string tag, input ins_t t, input int stall);
    int maxd = 0;
    if (t.s0 == 2) maxd = t.d0;
    if (t.s1 == 2 && t.d1 > maxd) maxd = t.d1;
    drive_accept(t);
    out_allowin = 1'($urandom);
    #1;
    chk({tag, ".empty_allowin"}, in_allowin, 1);
    chk({tag, ".empty_valid"}, out_valid, 0);
    chk({tag, ".empty_res"}, out_alu_res, 0);
    tick();
    for (int c = 1; c <= maxd; c++) begin
      in_valid = 1'($urandom);
      scramble();
      set_fwd(t, c);
      out_allowin = 1'($urandom);
      #1;
      chk({tag, ".wait_valid"}, out_valid, 0);
      chk({tag, ".wait_allowin"}, in_allowin, 0);
      tick();
    end
    in_valid = 0;
    for (int s = 0; s <= stall; s++) begin
      scramble();
      set_fwd(t, 99);
      out_allowin = (s == stall);
      #1;
      check_out(tag, t);
      chk({tag, ".ready_allowin"}, in_allowin, s == stall);
      tick();
    end
  endtask
  initial begin
    ins_t t, u;
    rst = 1;
    flush = 0;
    in_valid = 0;
    out_allowin = 0;
    in_wnum = 0; in_rs_data = 0; in_imm = 0; in_is_reg = 0; in_fwd_sel = 0; in_aluop = 0;
    in_pc = 0; in_exc = 0; in_ov_en = 0; in_trap_en = 0; in_trap_kind = 0; in_br_kind = 0;
    in_br_target = 0; in_pred_take = 0; in_pred_dest = 0; fwd_data = 0; fwd_valid = 0;
    repeat (2) tick();
    rst = 0;
    #1;
    chk("reset.allowin", in_allowin, 1);
    chk("reset.valid", out_valid, 0);
    chk("reset.res", out_alu_res, 0);
    chk("reset.pc", out_pc, 0);
    chk("reset.exc", out_exc, 0);
    chk("reset.dest", out_corr_dest, 0);
    chk("reset.mispred", out_mispred, 0);
    tick();
    // signed overflow on immediates
    t = '{default: '0};
    t.wnum = 5'd3; t.pc = 32'h100; t.a = 32'h7fffffff; t.b = 32'd1; t.ov_en = 1;
    run_instr("add_ovf", t, 0);
    chk("add_ovf.last_res_seen", 64'(t.a + t.b), 64'h80000000);
    // operand parked on forward 2 for three cycles
    t = '{default: '0};
    t.wnum = 5'd4; t.pc = 32'h104; t.s0 = 2; t.f0 = 2; t.d0 = 3; t.a = 32'h5; t.b = 32'h3;
    run_instr("fwd_wait", t, 0);
    // BEQ taken but predicted not taken
    t = '{default: '0};
    t.wnum = 5'd0; t.pc = 32'h108; t.s0 = 1; t.s1 = 1; t.a = 32'd9; t.b = 32'd9;
    t.br = 3'd1; t.tgt = 32'h400; t.pt = 0;
    run_instr("beq", t, 0);
    // JR correctly predicted
    t = '{default: '0};
    t.wnum = 5'd0; t.pc = 32'h10c; t.s0 = 1; t.a = 32'h1000; t.br = 3'd7; t.pt = 1; t.pd = 32'h1000;
    run_instr("jr", t, 1);
    // stalled READY, then release with a new instruction accepted in the same cycle
    t = rand_ins(); t.s0 = 0; t.s1 = 1;
    u = rand_ins(); u.s0 = 1; u.s1 = 0;
    drive_accept(t);
    out_allowin = 0;
    #1;
    chk("stall.accept_allowin", in_allowin, 1);
    tick();
    in_valid = 0;
    for (int s = 0; s < 2; s++) begin
      scramble();
      set_fwd(t, 99);
      #1;
      check_out("stall_hold", t);
      chk("stall.hold_allowin", in_allowin, 0);
      tick();
    end
    drive_accept(u);
    out_allowin = 1;
    #1;
    check_out("stall_release", t);
    chk("stall.release_allowin", in_allowin, 1);
    tick();
    in_valid = 0;
    scramble();
    set_fwd(u, 99);
    #1;
    check_out("back_to_back", u);
    tick();
    // flush beats both handoff and a concurrent accept
    t = rand_ins(); t.s0 = 0; t.s1 = 0;
    u = rand_ins(); u.s0 = 0; u.s1 = 0; u.wnum = 5'd17;
    drive_accept(t);
    out_allowin = 1;
    #1;
    tick();
    drive_accept(u);
    flush = 1;
    #1;
    chk("flush.valid", out_valid, 0);
    chk("flush.allowin", in_allowin, 0);
    tick();
    flush = 0;
    in_valid = 0;
    #1;
    chk("flush.after_valid", out_valid, 0);
    chk("flush.after_allowin", in_allowin, 1);
    chk("flush.after_wnum", out_wnum, 0);
    chk("flush.after_res", out_alu_res, 0);
    tick();
    #1;
    chk("flush.dropped_valid", out_valid, 0);
    // asynchronous reset while parked in WAIT
    t = rand_ins(); t.s0 = 2; t.f0 = 1; t.d0 = 5; t.s1 = 0; t.wnum = 5'd9; t.pc = 32'hdead0;
    drive_accept(t);
    out_allowin = 1;
    #1;
    tick();
    in_valid = 0;
    set_fwd(t, 1);
    #1;
    chk("rst_wait.allowin_before", in_allowin, 0);
    chk("rst_wait.valid_before", out_valid, 0);
    rst = 1;
    #1;
    chk("rst_wait.allowin", in_allowin, 1);
    chk("rst_wait.valid", out_valid, 0);
    chk("rst_wait.wnum", out_wnum, 0);
    chk("rst_wait.pc", out_pc, 0);
    chk("rst_wait.res", out_alu_res, 0);
    tick();
    rst = 0;
    fwd_valid = 0;
    tick();
    #1;
    chk("rst_wait.after_allowin", in_allowin, 1);
    chk("rst_wait.after_valid", out_valid, 0);
    tick();
    for (int n = 0; n < 200; n++) begin
      t = rand_ins();
      run_instr("rand", t, $urandom_range(0, 2));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
